alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec.sv | 145 ++++++++++++++
 tb/tb_alu_exec.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// alu_exec: multi-cycle ALU with a three-state control FSM (Idle, Shift, Done).
// Build option ALU_BARREL_SHIFT_EN: when defined, SLL/SRL finish in one cycle
// through a barrel shifter, and the Shift state and its counter are not built.
// When undefined, shifts run one bit per cycle.
module alu_exec (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  alu_decode,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        zero,
  output logic        illegal
);

  localparam logic [3:0] OpAnd = 4'd0;
  localparam logic [3:0] OpOr  = 4'd1;
  localparam logic [3:0] OpAdd = 4'd2;
  localparam logic [3:0] OpSll = 4'd3;
  localparam logic [3:0] OpSub = 4'd6;
  localparam logic [3:0] OpXor = 4'd7;
  localparam logic [3:0] OpSrl = 4'd8;

`ifdef ALU_BARREL_SHIFT_EN
  typedef enum logic [0:0] {StIdle, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        illegal_q, illegal_d;
  logic [31:0] alu_val;
  logic        legal;

`ifndef ALU_BARREL_SHIFT_EN
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        left_q, left_d;
  logic [31:0] acc_shift;
  logic        enter_shift;
`endif

  // Single-cycle datapath on the live inputs; only used on the accept edge.
  // A shift by zero also lands here and yields op_a unchanged.
  always_comb begin
    alu_val = '0;
    legal   = 1'b1;
    case (alu_decode)
      OpAnd:   alu_val = op_a & op_b;
      OpOr:    alu_val = op_a | op_b;
      OpAdd:   alu_val = op_a + op_b;
      OpSub:   alu_val = op_a - op_b;
      OpXor:   alu_val = op_a ^ op_b;
      OpSll:   alu_val = op_a << op_b[4:0];
      OpSrl:   alu_val = op_a >> op_b[4:0];
      default: legal   = 1'b0;
    endcase
  end

  // Next-state and registered-output update logic.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifndef ALU_BARREL_SHIFT_EN
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    acc_shift   = left_q ? (acc_q << 1) : (acc_q >> 1);
    enter_shift = ((alu_decode == OpSll) || (alu_decode == OpSrl)) && (op_b[4:0] != 5'd0);
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
`ifndef ALU_BARREL_SHIFT_EN
          if (enter_shift) begin
            state_d = StShift;
            acc_d   = op_a;
            cnt_d   = op_b[4:0];
            left_d  = (alu_decode == OpSll);
          end else
`endif
          begin
            state_d   = StDone;
            result_d  = alu_val;
            zero_d    = (alu_val == 32'd0);
            illegal_d = ~legal;
          end
        end
      end
`ifndef ALU_BARREL_SHIFT_EN
      StShift: begin
        acc_d = acc_shift;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d   = StDone;
          result_d  = acc_shift;
          zero_d    = (acc_shift == 32'd0);
          illegal_d = 1'b0;
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      acc_q     <= '0;
      cnt_q     <= '0;
      left_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifndef ALU_BARREL_SHIFT_EN
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
`endif
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign result  = result_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  alu_decode;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  alu_exec dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .alu_decode (alu_decode),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit model_legal(input logic [3:0] code);
    return (code == 4'd0) || (code == 4'd1) || (code == 4'd2) || (code == 4'd3) ||
           (code == 4'd6) || (code == 4'd7) || (code == 4'd8);
  endfunction

  // Shifts expressed as multiply/divide by a power of two, wrapped to 32 bits.
  function automatic logic [31:0] model_result(input logic [3:0] code, input logic [31:0] a,
                                               input logic [31:0] b);
    logic [31:0] pow;
    pow = 32'd1 << b[4:0];
    case (code)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a * pow;
      4'd6:    return a - b;
      4'd7:    return a ^ b;
      4'd8:    return a / pow;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_latency(input logic [3:0] code, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    if ((code == 4'd3 || code == 4'd8) && b[4:0] != 5'd0) return 1 + int'(b[4:0]);
    return 1;
`endif
  endfunction

  // Issue one op from Idle (called #1 after an edge), scramble inputs after the
  // accept edge, and verify latency, busy, outputs and the return to Idle.
  task automatic run_op(input string tag, input logic [3:0] code, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] exp_res;
    int          exp_lat;
    int          lat;
    exp_res = model_result(code, a, b);
    exp_lat = model_latency(code, b);
    check({tag, "_idle_busy"}, busy, 0);
    start = 1'b1; alu_decode = code; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; alu_decode = 4'($urandom); op_a = $urandom; op_b = $urandom;
    lat = 1;
    while (done !== 1'b1 && lat < 64) begin
      check({tag, "_busy_wait"}, busy, 1);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_done"}, busy, 1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_zero"}, zero, (exp_res == 32'd0));
    check({tag, "_illegal"}, illegal, !model_legal(code));
    @(posedge clk); #1;
    check({tag, "_done_low"}, done, 0);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_hold"}, result, exp_res);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; alu_decode = 4'd0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_illegal", illegal, 0);

    // First edge with rst_n high accepts the start.
    rst_n = 1'b1;
    run_op("add_5_7", 4'd2, 32'd5, 32'd7);
    run_op("sub_wrap", 4'd6, 32'd3, 32'd5);
    run_op("sub_zero", 4'd6, 32'h1234, 32'h1234);
    run_op("sll_31", 4'd3, 32'd1, 32'd31);
    run_op("srl_4", 4'd8, 32'h8000_0000, 32'd4);
    run_op("sll_0", 4'd3, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
    run_op("illegal_4", 4'd4, 32'hFFFF_FFFF, 32'd1);
    run_op("add_after_ill", 4'd2, 32'hFFFF_FFFF, 32'd1);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] code;
      code = (i % 8 == 7) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      run_op("rand", code, $urandom, $urandom);
    end

`ifndef ALU_BARREL_SHIFT_EN
    // Reset during a long shift: start retrigger ignored, no done, all outputs cleared.
    start = 1'b1; alu_decode = 4'd3; op_a = 32'd1; op_b = 32'd20;
    @(posedge clk); #1;
    op_a = 32'h5555_AAAA;
    for (int e = 2; e < 10; e++) begin
      check("shift_nodone", done, 0);
      check("shift_busy", busy, 1);
      @(posedge clk); #1;
    end
    check("shift_nodone9", done, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_zero", zero, 0);
    check("midrst_illegal", illegal, 0);
    rst_n = 1'b1; start = 1'b0;
    run_op("add_after_rst", 4'd2, 32'd1, 32'd1);
`endif

    // Start held high: accepts on every other edge.
    start = 1'b1; alu_decode = 4'd2; op_a = 32'd1; op_b = 32'd1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("b2b_done", done, (i % 2 == 0));
      check("b2b_result", result, 32'd2);
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("b2b_end_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
